// File: rtl/augment_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | augment_pkg                                                          |
// | Shared constants and reader state type for the augmentation chain.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package augment_pkg;

    localparam int PIXEL_W     = 8;
    localparam int BRAM_ADDR_W = 11;
    localparam int IMG_W       = 28;
    localparam int IMG_H       = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_prefetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pixel_prefetch_fifo                                                  |
// | Small synchronous ring-buffer FIFO with combinational head output.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pixel_prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/read_augmented.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | read_augmented                                                       |
// | Streams one stored image out of the augmentation BRAM with a         |
// | credit-limited prefetch FIFO hiding the BRAM read latency.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module read_augmented #(
    parameter int IMG_W        = augment_pkg::IMG_W,
    parameter int IMG_H        = augment_pkg::IMG_H,
    parameter int ADDR_W       = augment_pkg::BRAM_ADDR_W,
    parameter int DATA_W       = augment_pkg::PIXEL_W,
    parameter int BRAM_LATENCY = 2,
    parameter int BASE_ADDR    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_data,
    output logic [DATA_W-1:0] pixel_o,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic              pixel_last,
    output logic              image_done,
    output logic              busy
);

    import augment_pkg::*;

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int DEPTH = BRAM_LATENCY + 2;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int SUM_W = OCC_W + 1;

    if (NPIX > (2 ** ADDR_W)) begin : g_chk_size
        $fatal(1, "read_augmented: IMG_W*IMG_H exceeds the BRAM address space");
    end
    if ((BRAM_LATENCY < 1) || (BRAM_LATENCY > 3)) begin : g_chk_lat
        $fatal(1, "read_augmented: BRAM_LATENCY must be 1..3");
    end

    rd_state_t               state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    addr_vld_q, addr_vld_d;
    logic [BRAM_LATENCY-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]        rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]        out_idx_q, out_idx_d;

    logic                    fifo_empty;
    logic                    unused_fifo_full;
    logic [OCC_W-1:0]        fifo_count;
    logic [DATA_W-1:0]       fifo_head;
    logic                    hs;
    logic [SUM_W-1:0]        occ;
    logic                    credit_ok;

    pixel_prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tag_q[BRAM_LATENCY-1]),
        .data_i  (bram_data),
        .pop_i   (hs),
        .head_o  (fifo_head),
        .full_o  (unused_fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign pixel_valid = ~fifo_empty;
    assign pixel_o     = fifo_head;
    assign hs          = pixel_valid & pixel_ready;
    assign pixel_last  = pixel_valid & (out_idx_q == CNT_W'(NPIX - 1));
    assign image_done  = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign bram_addr   = addr_q;

    // Slots committed = reads on the wire + FIFO contents; a pop this cycle
    // frees its slot immediately so the stream sustains one pixel per cycle.
    always_comb begin
        occ = SUM_W'(addr_vld_q);
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            occ = occ + SUM_W'(tag_q[i]);
        end
        occ       = occ + SUM_W'(fifo_count) - SUM_W'(hs);
        credit_ok = (occ < SUM_W'(DEPTH));
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        addr_vld_d = 1'b0;
        rd_idx_d   = rd_idx_q;
        out_idx_d  = out_idx_q;
        tag_d      = tag_q << 1;
        tag_d[0]   = addr_vld_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = (NPIX == 1) ? DRAIN : FETCH;
                    addr_d     = ADDR_W'(BASE_ADDR);
                    addr_vld_d = 1'b1;
                    rd_idx_d   = CNT_W'(1);
                    out_idx_d  = '0;
                end
            end
            FETCH: begin
                if (credit_ok) begin
                    addr_d     = addr_q + ADDR_W'(1);
                    addr_vld_d = 1'b1;
                    rd_idx_d   = rd_idx_q + CNT_W'(1);
                    if (rd_idx_q == CNT_W'(NPIX - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DRAIN;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The final handshake empties the pipeline: nothing else is in flight.
        if (hs) begin
            out_idx_d = out_idx_q + CNT_W'(1);
            if (out_idx_q == CNT_W'(NPIX - 1)) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            addr_vld_q <= 1'b0;
            tag_q      <= '0;
            rd_idx_q   <= '0;
            out_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            addr_vld_q <= addr_vld_d;
            tag_q      <= tag_d;
            rd_idx_q   <= rd_idx_d;
            out_idx_q  <= out_idx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_read_augmented.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_read_augmented                                                    |
// | Scoreboard bench: three reader lanes (latency 2/1/3, base 0/0/2000). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_read_augmented;

    localparam int NPIX = 784;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_n;
    logic [2:0]  start_s;
    logic [2:0]  push_s;
    logic [2:0]  ready_s;
    logic [2:0]  valid_s;
    logic [2:0]  last_s;
    logic [2:0]  done_s;
    logic [2:0]  busy_s;
    logic [7:0]  pix_s  [3];
    logic [10:0] addr_s [3];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        localparam int L    = (gi == 1) ? 1 : ((gi == 2) ? 3 : 2);
        localparam int BASE = (gi == 2) ? 2000 : 0;

        logic [7:0]  bpipe [L];
        int unsigned exp_q [$];
        int          done_cnt = 0;
        logic        stall_q  = 1'b0;
        logic [7:0]  held_q   = 8'h00;

        read_augmented #(
            .IMG_W        (28),
            .IMG_H        (28),
            .ADDR_W       (11),
            .DATA_W       (8),
            .BRAM_LATENCY (L),
            .BASE_ADDR    (BASE)
        ) u_dut (
            .clk         (clk),
            .reset       (rst_n[gi]),
            .start       (start_s[gi]),
            .bram_addr   (addr_s[gi]),
            .bram_data   (bpipe[L-1]),
            .pixel_o     (pix_s[gi]),
            .pixel_valid (valid_s[gi]),
            .pixel_ready (ready_s[gi]),
            .pixel_last  (last_s[gi]),
            .image_done  (done_s[gi]),
            .busy        (busy_s[gi])
        );

        // BRAM model: mem[a] = a[7:0], L-cycle read pipeline.
        always @(posedge clk) begin
            bpipe[0] <= addr_s[gi][7:0];
            for (int p = 1; p < L; p++) begin
                bpipe[p] <= bpipe[p-1];
            end
        end

        always @(negedge clk) begin
            if (!rst_n[gi]) begin
                exp_q.delete();
                stall_q <= 1'b0;
            end else begin
                if (push_s[gi]) begin
                    for (int p = 0; p < NPIX; p++) begin
                        exp_q.push_back(((BASE + p) % 2048) % 256);
                    end
                end
                if (stall_q) begin
                    check($sformatf("l%0d_stall_hold", gi), longint'(pix_s[gi]), longint'(held_q));
                    check($sformatf("l%0d_stall_valid", gi), longint'(valid_s[gi]), 1);
                end
                if (valid_s[gi] && ready_s[gi]) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("l%0d_extra_pixel", gi), 1, 0);
                    end else begin
                        check($sformatf("l%0d_pixel", gi), longint'(pix_s[gi]),
                              longint'(exp_q.pop_front()));
                        check($sformatf("l%0d_last", gi), longint'(last_s[gi]),
                              longint'(exp_q.size() == 0));
                    end
                end
                if (done_s[gi]) begin
                    check($sformatf("l%0d_done_empty", gi), longint'(exp_q.size()), 0);
                    done_cnt <= done_cnt + 1;
                end
                stall_q <= valid_s[gi] & ~ready_s[gi];
                held_q  <= pix_s[gi];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i, input logic accept);
        start_s[i] = 1'b1;
        push_s[i]  = accept;
        tick();
        start_s[i] = 1'b0;
        push_s[i]  = 1'b0;
    endtask

    task automatic wait_valid(input int i, output int k);
        k = 0;
        while (!valid_s[i] && k < 100) begin
            tick();
            k++;
        end
        if (!valid_s[i]) check("valid_timeout", 0, 1);
    endtask

    task automatic wait_done(input int i, output int k);
        k = 0;
        while (!done_s[i] && k < 3000) begin
            tick();
            k++;
        end
        if (!done_s[i]) check("done_timeout", 0, 1);
    endtask

    task automatic count_hs(input int i, input int n);
        int hs = 0;
        int k  = 0;
        while (hs < n && k < 3000) begin
            if (valid_s[i] && ready_s[i]) hs++;
            tick();
            k++;
        end
        if (hs < n) check("hs_timeout", longint'(hs), longint'(n));
    endtask

    task automatic check_idle(input int i, input string tag);
        check({tag, "_addr"},  longint'(addr_s[i]),  0);
        check({tag, "_pix"},   longint'(pix_s[i]),   0);
        check({tag, "_valid"}, longint'(valid_s[i]), 0);
        check({tag, "_last"},  longint'(last_s[i]),  0);
        check({tag, "_done"},  longint'(done_s[i]),  0);
        check({tag, "_busy"},  longint'(busy_s[i]),  0);
    endtask

    initial begin
        int k;
        int k2;
        logic d1;
        logic d2;
        rst_n   = 3'b000;
        start_s = 3'b000;
        push_s  = 3'b000;
        ready_s = 3'b111;
        repeat (3) tick();
        check_idle(0, "rst");
        check_idle(2, "rst_l3");
        rst_n = 3'b111;
        tick();

        // Basic image: latency and throughput with ready high.
        pulse_start(0, 1'b1);
        check("t1_busy", longint'(busy_s[0]), 1);
        check("t1_addr", longint'(addr_s[0]), 0);
        wait_valid(0, k);
        check("t1_first_lat", longint'(k), 3);
        check("t1_first_pix", longint'(pix_s[0]), 0);
        wait_done(0, k);
        check("t1_done_lat", longint'(k), NPIX);
        check("t1_busy_in_done", longint'(busy_s[0]), 1);
        tick();
        check("t1_busy_drop", longint'(busy_s[0]), 0);
        check("t1_done_pulse", longint'(done_s[0]), 0);

        // start while busy and in the DONE cycle is ignored.
        pulse_start(0, 1'b1);
        count_hs(0, 100);
        pulse_start(0, 1'b0);
        check("t2_busy_repulse", longint'(busy_s[0]), 1);
        wait_done(0, k);
        pulse_start(0, 1'b0);
        check("t2_done_start", longint'(busy_s[0]), 0);
        repeat (5) tick();
        check("t2_idle_busy", longint'(busy_s[0]), 0);
        check("t2_idle_valid", longint'(valid_s[0]), 0);
        pulse_start(0, 1'b1);
        wait_done(0, k);
        check("t2_second_lat", longint'(k), NPIX + 3);
        tick();

        // Reset mid-image, then a clean image.
        pulse_start(0, 1'b1);
        count_hs(0, 300);
        rst_n[0] = 1'b0;
        tick();
        check_idle(0, "t3");
        tick();
        rst_n[0] = 1'b1;
        tick();
        pulse_start(0, 1'b1);
        wait_valid(0, k);
        check("t3_first_lat", longint'(k), 3);
        check("t3_first_pix", longint'(pix_s[0]), 0);
        wait_done(0, k);
        tick();

        // 50-cycle stall right after the first valid.
        pulse_start(0, 1'b1);
        wait_valid(0, k);
        ready_s[0] = 1'b0;
        repeat (50) tick();
        ready_s[0] = 1'b1;
        wait_done(0, k2);
        check("t4_done_lat", longint'(50 + k2), NPIX + 50);
        tick();

        // Random backpressure on the latency-1 and latency-3/base-2000 lanes.
        start_s[1] = 1'b1; push_s[1] = 1'b1;
        start_s[2] = 1'b1; push_s[2] = 1'b1;
        tick();
        start_s[1] = 1'b0; push_s[1] = 1'b0;
        start_s[2] = 1'b0; push_s[2] = 1'b0;
        check("t5_l3_addr", longint'(addr_s[2]), 2000);
        d1 = 1'b0;
        d2 = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (done_s[1]) d1 = 1'b1;
            if (done_s[2]) d2 = 1'b1;
            if (d1 && d2) break;
            ready_s[1] = 1'($urandom_range(0, 1));
            ready_s[2] = 1'($urandom_range(0, 1));
            tick();
        end
        check("t5_l1_done", longint'(d1), 1);
        check("t5_l3_done", longint'(d2), 1);
        ready_s = 3'b111;
        repeat (4) tick();

        check("l0_done_count", longint'(g_lane[0].done_cnt), 5);
        check("l1_done_count", longint'(g_lane[1].done_cnt), 1);
        check("l2_done_count", longint'(g_lane[2].done_cnt), 1);
        check("l0_queue_left", longint'(g_lane[0].exp_q.size()), 0);
        check("l1_queue_left", longint'(g_lane[1].exp_q.size()), 0);
        check("l2_queue_left", longint'(g_lane[2].exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
